// File: rtl/control_register_pipe.sv
//-----------------------------------------------------------------------------
// control_register_pipe
//
// Pipelined microinstruction control register. Sits between the microstore /
// encoder and the datapath plus next-state logic. Each of DEPTH stages holds
// one control word, its transition fields, the state that produced it and a
// valid bit. The pipeline supports stall (hold everything), flush (empty every
// stage to NOP) and a stall watchdog that flags a pipeline held for too long.
//
// Parameters
//   CW_W      datapath control word width
//   NS_W      transition field width (N2..N0, Inv, S1, S0, CR4..CR0)
//   ST_W      state number width
//   DEPTH     number of pipeline stages, 1..4
//   NOP_WORD  control word held by empty, flushed or reset stages
//   STALL_MAX stalled edges before stall_timeout asserts, 1..255
//
// Ports
//   clk            rising-edge clock
//   reset_n        asynchronous active-low reset
//   ctrl_in        control word from the microstore
//   ns_in          transition fields
//   state_in       state that produced this word
//   valid_in       1 = real word, 0 = bubble
//   stall          hold all stages, drop the input word
//   flush          empty all stages (wins over stall)
//   ctrl_out       last-stage control word
//   ns_out         last-stage transition fields
//   state_out      last-stage state
//   valid_out      last stage holds a real word
//   occupancy      number of valid stages, 0..DEPTH
//   stall_timeout  watchdog flag, registered
//   parity_err     (CR_PARITY_EN only) sticky parity error on the last stage
//
// Optional feature
//   Define CR_PARITY_EN to add a per-stage even-parity bit over {ctrl, ns}
//   and the parity_err output. Without it the design has no parity storage.
//-----------------------------------------------------------------------------
module control_register_pipe #(
   parameter int              CW_W      = 40,
   parameter int              NS_W      = 11,
   parameter int              ST_W      = 5,
   parameter int              DEPTH     = 1,
   parameter logic [CW_W-1:0] NOP_WORD  = {CW_W{1'b0}},
   parameter int              STALL_MAX = 15
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic [CW_W-1:0] ctrl_in,
   input  logic [NS_W-1:0] ns_in,
   input  logic [ST_W-1:0] state_in,
   input  logic            valid_in,
   input  logic            stall,
   input  logic            flush,
   output logic [CW_W-1:0] ctrl_out,
   output logic [NS_W-1:0] ns_out,
   output logic [ST_W-1:0] state_out,
   output logic            valid_out,
   output logic [2:0]      occupancy,
   output logic            stall_timeout
`ifdef CR_PARITY_EN
   ,
   output logic            parity_err
`endif
);

   localparam int         LAST      = DEPTH - 1;
   localparam logic [7:0] STALL_LIM = 8'(STALL_MAX);

   //--------------------------------------------------------------------------
   // Helper functions
   //--------------------------------------------------------------------------

   // Saturating increment for the 8-bit stall watchdog.
   function automatic logic [7:0] sat_inc(input logic [7:0] c);
      return (c == 8'hFF) ? c : c + 8'd1;
   endfunction

   // Population count of the stage valid bits; DEPTH <= 4 fits in 3 bits.
   function automatic logic [2:0] count_valid(input logic [DEPTH-1:0] v);
      logic [2:0] n;
      n = 3'd0;
      for (int k = 0; k < DEPTH; k++) begin
         n = n + {2'b00, v[k]};
      end
      return n;
   endfunction

`ifdef CR_PARITY_EN
   // Even parity: the stored bit makes the XOR over {ctrl, ns, par} zero.
   function automatic logic word_parity(input logic [CW_W-1:0] c,
                                        input logic [NS_W-1:0] n);
      return ^{c, n};
   endfunction
`endif

   //--------------------------------------------------------------------------
   // Stage storage (index 0 = entry stage, LAST = output stage)
   //--------------------------------------------------------------------------
   logic [DEPTH-1:0][CW_W-1:0] ctrl_p;
   logic [DEPTH-1:0][NS_W-1:0] ns_p;
   logic [DEPTH-1:0][ST_W-1:0] state_p;
   logic [DEPTH-1:0]           vld_p;

   // Stage0 entry values: a bubble carries NOP and empty transition fields
   // but still records the state that produced it.
   logic [CW_W-1:0] ctrl_d0;
   logic [NS_W-1:0] ns_d0;

   assign ctrl_d0 = valid_in ? ctrl_in : NOP_WORD;
   assign ns_d0   = valid_in ? ns_in   : {NS_W{1'b0}};

   //--------------------------------------------------------------------------
   // Pipeline registers: stage0 <- inputs, stage k <- stage k-1
   //--------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int k = 0; k < DEPTH; k++) begin
            ctrl_p[k]  <= NOP_WORD;
            ns_p[k]    <= {NS_W{1'b0}};
            state_p[k] <= {ST_W{1'b0}};
         end
         vld_p <= {DEPTH{1'b0}};
      end else if (flush) begin
         // Flush empties every stage but leaves the state fields alone so the
         // next-state logic still sees where each slot came from.
         for (int k = 0; k < DEPTH; k++) begin
            ctrl_p[k] <= NOP_WORD;
            ns_p[k]   <= {NS_W{1'b0}};
         end
         vld_p <= {DEPTH{1'b0}};
      end else if (!stall) begin
         ctrl_p[0]  <= ctrl_d0;
         ns_p[0]    <= ns_d0;
         state_p[0] <= state_in;
         vld_p[0]   <= valid_in;
         for (int k = 1; k < DEPTH; k++) begin
            ctrl_p[k]  <= ctrl_p[k-1];
            ns_p[k]    <= ns_p[k-1];
            state_p[k] <= state_p[k-1];
            vld_p[k]   <= vld_p[k-1];
         end
      end
      // stall without flush: every stage holds, the input word is dropped
   end

   //--------------------------------------------------------------------------
   // Outputs straight from the last stage
   //--------------------------------------------------------------------------
   assign ctrl_out  = ctrl_p[LAST];
   assign ns_out    = ns_p[LAST];
   assign state_out = state_p[LAST];
   assign valid_out = vld_p[LAST];
   assign occupancy = count_valid(vld_p);

   //--------------------------------------------------------------------------
   // Stall watchdog
   //--------------------------------------------------------------------------
   logic [7:0] stall_cnt;
   logic [7:0] stall_cnt_nxt;

   // Any edge that is not a pure stall (stall low, or flush) restarts the
   // count; the flag is derived from the next count so it tracks the counter
   // on the same edge.
   assign stall_cnt_nxt = (flush || !stall) ? 8'd0 : sat_inc(stall_cnt);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stall_cnt     <= 8'd0;
         stall_timeout <= 1'b0;
      end else begin
         stall_cnt     <= stall_cnt_nxt;
         stall_timeout <= (stall_cnt_nxt >= STALL_LIM);
      end
   end

`ifdef CR_PARITY_EN
   //--------------------------------------------------------------------------
   // Parity storage and sticky error flag
   //--------------------------------------------------------------------------
   localparam logic NOP_PAR = ^NOP_WORD;

   logic [DEPTH-1:0] par_p;
   logic             par_d0;
   logic             last_par_bad;

   // Computed from the stored entry word, so bubbles get the NOP parity.
   assign par_d0       = word_parity(ctrl_d0, ns_d0);
   assign last_par_bad = vld_p[LAST] &&
                         (word_parity(ctrl_p[LAST], ns_p[LAST]) != par_p[LAST]);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         par_p      <= {DEPTH{NOP_PAR}};
         parity_err <= 1'b0;
      end else if (flush) begin
         par_p      <= {DEPTH{NOP_PAR}};
         parity_err <= 1'b0;
      end else begin
         if (!stall) begin
            par_p[0] <= par_d0;
            for (int k = 1; k < DEPTH; k++) begin
               par_p[k] <= par_p[k-1];
            end
         end
         parity_err <= parity_err | last_par_bad;
      end
   end
`endif

endmodule

// File: tb/tb_control_register_pipe.sv
//-----------------------------------------------------------------------------
// Self-checking bench for control_register_pipe.
// Two instances share one input set: dut (DEPTH=2, NOP_WORD=0) and
// dut1 (DEPTH=1, non-zero NOP_WORD). Directed table vectors, hand-written
// corner sequences and a randomized phase checked against a queue model.
//-----------------------------------------------------------------------------
module tb_control_register_pipe;

   localparam logic [39:0] NOP1 = 40'hA5_0000_005A;

   logic        clk = 1'b0;
   logic        reset_n = 1'b1;
   logic [39:0] ctrl_in = '0;
   logic [10:0] ns_in = '0;
   logic [4:0]  state_in = '0;
   logic        valid_in = 1'b0;
   logic        stall = 1'b0;
   logic        flush = 1'b0;

   logic [39:0] ctrl2, ctrl1;
   logic [10:0] ns2, ns1;
   logic [4:0]  st2, st1;
   logic        v2, v1;
   logic [2:0]  occ2, occ1;
   logic        to2, to1;
`ifdef CR_PARITY_EN
   logic        pe2, pe1;
`endif

   always #5 clk = ~clk;

   control_register_pipe #(.DEPTH(2), .NOP_WORD(40'h0), .STALL_MAX(15)) dut (
      .clk(clk), .reset_n(reset_n), .ctrl_in(ctrl_in), .ns_in(ns_in),
      .state_in(state_in), .valid_in(valid_in), .stall(stall), .flush(flush),
      .ctrl_out(ctrl2), .ns_out(ns2), .state_out(st2), .valid_out(v2),
      .occupancy(occ2), .stall_timeout(to2)
`ifdef CR_PARITY_EN
      , .parity_err(pe2)
`endif
   );

   control_register_pipe #(.DEPTH(1), .NOP_WORD(NOP1), .STALL_MAX(15)) dut1 (
      .clk(clk), .reset_n(reset_n), .ctrl_in(ctrl_in), .ns_in(ns_in),
      .state_in(state_in), .valid_in(valid_in), .stall(stall), .flush(flush),
      .ctrl_out(ctrl1), .ns_out(ns1), .state_out(st1), .valid_out(v1),
      .occupancy(occ1), .stall_timeout(to1)
`ifdef CR_PARITY_EN
      , .parity_err(pe1)
`endif
   );

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   //--------------------------------------------------------------------------
   // Reference model: each pipeline is a queue, front = newest, back = output.
   //--------------------------------------------------------------------------
   typedef struct packed {
      logic [39:0] c;
      logic [10:0] n;
      logic [4:0]  s;
      logic        v;
   } ent_t;

   ent_t m2[$];
   ent_t m1[$];
   int   wd;

   function automatic ent_t entry(input logic [39:0] nop);
      ent_t e;
      e.c = valid_in ? ctrl_in : nop;
      e.n = valid_in ? ns_in : 11'd0;
      e.s = state_in;
      e.v = valid_in;
      return e;
   endfunction

   task automatic model_reset();
      ent_t e;
      m2 = {};
      m1 = {};
      e = '{c: 40'd0, n: 11'd0, s: 5'd0, v: 1'b0};
      m2.push_back(e);
      m2.push_back(e);
      e.c = NOP1;
      m1.push_back(e);
      wd = 0;
   endtask

   task automatic model_step();
      ent_t e;
      if (flush) begin
         foreach (m2[i]) begin
            e = m2[i]; e.c = 40'd0; e.n = 11'd0; e.v = 1'b0; m2[i] = e;
         end
         foreach (m1[i]) begin
            e = m1[i]; e.c = NOP1; e.n = 11'd0; e.v = 1'b0; m1[i] = e;
         end
      end else if (!stall) begin
         m2.push_front(entry(40'd0));
         void'(m2.pop_back());
         m1.push_front(entry(NOP1));
         void'(m1.pop_back());
      end
      if (flush || !stall) wd = 0;
      else if (wd < 255) wd++;
   endtask

   function automatic int count_q2();
      int n = 0;
      foreach (m2[i]) n += int'(m2[i].v);
      return n;
   endfunction

   task automatic check_models();
      ent_t e2, e1;
      e2 = m2[m2.size()-1];
      e1 = m1[m1.size()-1];
      chk("d2_ctrl",  64'(ctrl2), 64'(e2.c));
      chk("d2_ns",    64'(ns2),   64'(e2.n));
      chk("d2_state", 64'(st2),   64'(e2.s));
      chk("d2_valid", 64'(v2),    64'(e2.v));
      chk("d2_occ",   64'(occ2),  64'(count_q2()));
      chk("d2_to",    64'(to2),   64'(wd >= 15));
      chk("d1_ctrl",  64'(ctrl1), 64'(e1.c));
      chk("d1_ns",    64'(ns1),   64'(e1.n));
      chk("d1_state", 64'(st1),   64'(e1.s));
      chk("d1_valid", 64'(v1),    64'(e1.v));
      chk("d1_occ",   64'(occ1),  64'(e1.v));
      chk("d1_to",    64'(to1),   64'(wd >= 15));
`ifdef CR_PARITY_EN
      chk("d2_perr",  64'(pe2),   64'd0);
      chk("d1_perr",  64'(pe1),   64'd0);
`endif
   endtask

   task automatic tick();
      @(posedge clk);
      if (reset_n) model_step();
      #1;
   endtask

   task automatic drive(input logic [39:0] c, input logic [10:0] n, input logic [4:0] s,
                        input logic v, input logic stl, input logic fl);
      ctrl_in = c; ns_in = n; state_in = s; valid_in = v; stall = stl; flush = fl;
   endtask

   //--------------------------------------------------------------------------
   // Directed vectors for the DEPTH=2 instance
   //--------------------------------------------------------------------------
   typedef struct {
      logic [39:0] c;  logic [10:0] n;  logic [4:0] s;
      logic        v;  logic stl;       logic fl;
      logic [39:0] ec; logic [10:0] en; logic [4:0] es;
      logic        ev; logic [2:0] eo;
   } vec_t;

   vec_t tbl[11];

   initial begin
      logic [39:0] oh;
      logic [10:0] ohn;
      logic [39:0] w1, w2;

      tbl[0]  = '{40'h00_0000_0001, 11'h001, 5'd3,  1, 0, 0, 40'h0,            11'h000, 5'd0, 0, 3'd1};
      tbl[1]  = '{40'h80_0000_0000, 11'h400, 5'd4,  1, 0, 0, 40'h00_0000_0001, 11'h001, 5'd3, 1, 3'd2};
      tbl[2]  = '{40'h12_3456_789A, 11'h2AB, 5'd5,  1, 0, 0, 40'h80_0000_0000, 11'h400, 5'd4, 1, 3'd2};
      tbl[3]  = '{40'hFF_FFFF_FFFF, 11'h7FF, 5'd7,  0, 0, 0, 40'h12_3456_789A, 11'h2AB, 5'd5, 1, 3'd1};
      tbl[4]  = '{40'h0F_0F0F_0F0F, 11'h0F0, 5'd10, 1, 1, 0, 40'h12_3456_789A, 11'h2AB, 5'd5, 1, 3'd1};
      tbl[5]  = '{40'h00_0000_0011, 11'h011, 5'd9,  0, 0, 0, 40'h0,            11'h000, 5'd7, 0, 3'd0};
      tbl[6]  = '{40'h33_0000_0033, 11'h033, 5'd2,  1, 0, 0, 40'h0,            11'h000, 5'd9, 0, 3'd1};
      tbl[7]  = '{40'h44_4400_0000, 11'h444, 5'd6,  1, 0, 0, 40'h33_0000_0033, 11'h033, 5'd2, 1, 3'd2};
      tbl[8]  = '{40'h55_5555_5555, 11'h555, 5'd1,  1, 1, 1, 40'h0,            11'h000, 5'd2, 0, 3'd0};
      tbl[9]  = '{40'h66_0000_0066, 11'h066, 5'd8,  1, 0, 0, 40'h0,            11'h000, 5'd6, 0, 3'd1};
      tbl[10] = '{40'h00_0000_0000, 11'h000, 5'd0,  0, 0, 0, 40'h66_0000_0066, 11'h066, 5'd8, 1, 3'd1};

      // Reset and release
      #2 reset_n = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ctrl2",  64'(ctrl2), 64'd0);
      chk("rst_valid2", 64'(v2),    64'd0);
      chk("rst_occ2",   64'(occ2),  64'd0);
      chk("rst_state2", 64'(st2),   64'd0);
      chk("rst_to2",    64'(to2),   64'd0);
      chk("rst_ctrl1",  64'(ctrl1), 64'(NOP1));
      @(negedge clk) reset_n = 1'b1;

      // Table-driven directed sequence
      foreach (tbl[i]) begin
         drive(tbl[i].c, tbl[i].n, tbl[i].s, tbl[i].v, tbl[i].stl, tbl[i].fl);
         tick();
         chk($sformatf("tbl%0d_ctrl", i),  64'(ctrl2), 64'(tbl[i].ec));
         chk($sformatf("tbl%0d_ns", i),    64'(ns2),   64'(tbl[i].en));
         chk($sformatf("tbl%0d_state", i), 64'(st2),   64'(tbl[i].es));
         chk($sformatf("tbl%0d_valid", i), 64'(v2),    64'(tbl[i].ev));
         chk($sformatf("tbl%0d_occ", i),   64'(occ2),  64'(tbl[i].eo));
         check_models();
      end

      // Bit-isolation walk on the DEPTH=1 instance
      for (int i = 0; i < 40; i++) begin
         oh = 40'd1 << i;
         drive(oh, 11'd0, 5'd1, 1, 0, 0);
         tick();
         chk($sformatf("walk_ctrl%0d", i), 64'(ctrl1), 64'(oh));
         chk($sformatf("walk_ctrl%0d_ns", i), 64'(ns1), 64'd0);
      end
      for (int i = 0; i < 11; i++) begin
         ohn = 11'd1 << i;
         drive(40'd0, ohn, 5'd2, 1, 0, 0);
         tick();
         chk($sformatf("walk_ns%0d", i), 64'(ns1), 64'(ohn));
         chk($sformatf("walk_ns%0d_ctrl", i), 64'(ctrl1), 64'd0);
      end
      oh = 40'd1 << 38;                       // MARld alone
      drive(oh, 11'd0, 5'd3, 1, 0, 0);
      tick();
      chk("marld_only_mdrld", 64'(ctrl1[37]), 64'd0);
      chk("marld_only_marld", 64'(ctrl1[38]), 64'd1);
      check_models();

      // Full pipeline, long stall, watchdog
      w1 = 40'hC0_FFEE_0001;
      w2 = 40'hBE_EF00_0002;
      drive(w1, 11'h101, 5'd11, 1, 0, 0); tick();
      drive(w2, 11'h202, 5'd12, 1, 0, 0); tick();
      drive(40'h99_9999_9999, 11'h399, 5'd13, 1, 1, 0);
      for (int k = 1; k <= 20; k++) begin
         tick();
         chk($sformatf("wd_to_k%0d", k),   64'(to2),   64'(k >= 15));
         chk($sformatf("wd_ctrl_k%0d", k), 64'(ctrl2), 64'(w1));
         chk($sformatf("wd_occ_k%0d", k),  64'(occ2),  64'd2);
      end
      check_models();
      drive(40'd0, 11'd0, 5'd0, 0, 0, 0);
      tick();
      chk("wd_drop_to",   64'(to2),   64'd0);
      chk("wd_drop_ctrl", 64'(ctrl2), 64'(w2));
      check_models();

      // Full pipeline, flush together with stall and a valid input word
      drive(w1, 11'h101, 5'd11, 1, 0, 0); tick();
      drive(w2, 11'h202, 5'd12, 1, 0, 0); tick();
      drive(40'h77_7777_7777, 11'h777, 5'd14, 1, 1, 1);
      tick();
      chk("fl_valid", 64'(v2),    64'd0);
      chk("fl_ctrl",  64'(ctrl2), 64'd0);
      chk("fl_occ",   64'(occ2),  64'd0);
      chk("fl_to",    64'(to2),   64'd0);
      drive(40'd0, 11'd0, 5'd0, 0, 0, 0);
      for (int k = 0; k < 2; k++) begin
         tick();
         chk($sformatf("fl_after%0d_valid", k), 64'(v2),    64'd0);
         chk($sformatf("fl_after%0d_ctrl", k),  64'(ctrl2), 64'd0);
      end
      check_models();

      // Asynchronous reset mid-run, mid-stall with two valid words
      drive(w1, 11'h101, 5'd11, 1, 0, 0); tick();
      drive(w2, 11'h202, 5'd12, 1, 0, 0); tick();
      drive(w2, 11'h202, 5'd12, 1, 1, 0);
      repeat (16) tick();
      chk("pre_rst_to", 64'(to2), 64'd1);
      #2 reset_n = 1'b0;
      #1;
      model_reset();
      chk("arst_ctrl2",  64'(ctrl2), 64'd0);
      chk("arst_ns2",    64'(ns2),   64'd0);
      chk("arst_state2", 64'(st2),   64'd0);
      chk("arst_valid2", 64'(v2),    64'd0);
      chk("arst_occ2",   64'(occ2),  64'd0);
      chk("arst_to2",    64'(to2),   64'd0);
      chk("arst_ctrl1",  64'(ctrl1), 64'(NOP1));
      drive(40'd0, 11'd0, 5'd0, 0, 0, 0);
      @(negedge clk) reset_n = 1'b1;
      tick();
      check_models();

      // Randomized phase against the queue model
      for (int i = 0; i < 400; i++) begin
         ctrl_in  = {8'($urandom), 32'($urandom)};
         ns_in    = 11'($urandom);
         state_in = 5'($urandom);
         valid_in = ($urandom_range(3, 0) != 0);
         stall    = stall ? ($urandom_range(7, 0) != 0) : ($urandom_range(5, 0) == 0);
         flush    = ($urandom_range(15, 0) == 0);
         tick();
         check_models();
      end

`ifdef CR_PARITY_EN
      // Corrupt a stored bit of the last stage (stage1) and watch parity_err
      drive(40'd0, 11'd0, 5'd0, 0, 0, 1); tick();
      drive(40'h00_0000_0F00, 11'h000, 5'd4, 1, 0, 0); tick();
      drive(40'h00_0000_0003, 11'h005, 5'd5, 1, 0, 0); tick();
      chk("par_clean", 64'(pe2), 64'd0);
      force dut.ctrl_p[1][0] = 1'b1;
      drive(40'h00_0000_0030, 11'h006, 5'd6, 1, 0, 0); tick();
      chk("par_rise", 64'(pe2), 64'd1);
      release dut.ctrl_p[1][0];
      for (int k = 0; k < 3; k++) begin
         drive(40'h00_0000_0100 + 40'(k), 11'h010, 5'd7, 1, 0, 0);
         tick();
         chk($sformatf("par_sticky%0d", k), 64'(pe2), 64'd1);
      end
      chk("par_other_inst", 64'(pe1), 64'd0);
      drive(40'd0, 11'd0, 5'd0, 0, 0, 1); tick();
      chk("par_flush_clear", 64'(pe2), 64'd0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
